// File: rtl/gf2m_mul_seq.sv
// Command sequencer for one GF(2^m) shift-and-add multiplier: load, multiply burst, two-half readout.
// Optional completion checking is enabled by defining GF2M_MUL_SEQ_CHECK_EN.
module gf2m_mul_seq #(
  parameter int WIDTH    = 256,
  parameter int MUL_STEP = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mod,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_err,
  output logic             busy,
  output logic             mul_mod_mul,
  output logic             mul_plain_mul,
  output logic             mul_stos,
  output logic             mul_stox,
  output logic             mul_clear,
  output logic             mul_dbus_sel,
  output logic [WIDTH-1:0] mul_sbus,
  input  logic [WIDTH-1:0] mul_dbus,
  input  logic             mul_done
);

  localparam int N  = WIDTH / MUL_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (MUL_STEP < 1 || (WIDTH % MUL_STEP) != 0) begin : g_bad_step
      $error("gf2m_mul_seq: MUL_STEP must divide WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_LOAD_S, S_MUL, S_WAIT, S_RD_LO, S_RD_HI, S_RESP
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic            mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      rsp_lo <= '0;
      rsp_hi <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && cmd_valid) begin
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        mode_q <= cmd_mod;
      end
      if (state == S_MUL) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (state == S_RD_LO) rsp_lo <= mul_dbus;
      if (state == S_RD_HI) rsp_hi <= mul_dbus;
    end
  end

  // Strobes decode from state alone, so they drop the moment reset_n falls.
  always_comb begin
    nxt           = state;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    rsp_valid     = 1'b0;
    mul_stox      = 1'b0;
    mul_stos      = 1'b0;
    mul_clear     = 1'b0;
    mul_mod_mul   = 1'b0;
    mul_plain_mul = 1'b0;
    mul_dbus_sel  = 1'b0;
    mul_sbus      = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) nxt = S_LOAD_X;
      end
      S_LOAD_X: begin
        mul_stox = 1'b1;
        mul_sbus = a_q;
        nxt      = S_LOAD_S;
      end
      S_LOAD_S: begin
        mul_stos  = 1'b1;
        mul_clear = 1'b1;
        mul_sbus  = b_q;
        nxt       = S_MUL;
      end
      S_MUL: begin
        mul_mod_mul   = mode_q;
        mul_plain_mul = ~mode_q;
        if (cnt == LAST) nxt = S_WAIT;
      end
      S_WAIT:  nxt = S_RD_LO;
      S_RD_LO: nxt = S_RD_HI;
      S_RD_HI: begin
        mul_dbus_sel = 1'b1;
        nxt          = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

`ifdef GF2M_MUL_SEQ_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && cmd_valid) begin
      err_q <= 1'b0;
    end else if ((state == S_LOAD_X || state == S_LOAD_S || state == S_WAIT) && !mul_done) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q & (state == S_RESP);
`else
  logic unused_done;
  assign unused_done = mul_done;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gf2m_mul_seq.sv
// Bench for gf2m_mul_seq: behavioural multiplier stand-in, cycle-offset reference model and
// per-cycle compare loop, plus directed vectors with hand-computed results.
module tb_gf2m_mul_seq;

  localparam int W = 256;
  localparam int S = 8;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid, cmd_ready, cmd_mod;
  logic [W-1:0] cmd_a, cmd_b;
  logic         rsp_valid, rsp_ready, rsp_err, busy;
  logic [W-1:0] rsp_lo, rsp_hi;
  logic         mul_mod_mul, mul_plain_mul, mul_stos, mul_stox, mul_clear, mul_dbus_sel;
  logic [W-1:0] mul_sbus, mul_dbus;
  logic         mul_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf2m_mul_seq #(.WIDTH(W), .MUL_STEP(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mod(cmd_mod),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy),
    .mul_mod_mul(mul_mod_mul), .mul_plain_mul(mul_plain_mul),
    .mul_stos(mul_stos), .mul_stox(mul_stox), .mul_clear(mul_clear),
    .mul_dbus_sel(mul_dbus_sel), .mul_sbus(mul_sbus),
    .mul_dbus(mul_dbus), .mul_done(mul_done)
  );

  // Carry-less product and reduction by x^163+x^7+x^6+x^3+1.
  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r = '0;
    logic [2*W-1:0] ax = {{W{1'b0}}, a};
    for (int i = 0; i < W; i++)
      if (b[i]) r = r ^ (ax << i);
    return r;
  endfunction

  function automatic logic [2*W-1:0] polyred(input logic [2*W-1:0] p);
    logic [2*W-1:0] poly = '0;
    logic [2*W-1:0] r = p;
    poly[163] = 1'b1; poly[7] = 1'b1; poly[6] = 1'b1; poly[3] = 1'b1; poly[0] = 1'b1;
    for (int i = 2*W-1; i >= 163; i--)
      if (r[i]) r = r ^ (poly << (i - 163));
    return r;
  endfunction

  // Stand-in multiplier: result valid after N mul strobes following an s load.
  logic [W-1:0]   fx, fs;
  logic [2*W-1:0] prod;
  logic           running, force_lo;
  int             pcnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fx <= '0; fs <= '0; prod <= '0; running <= 1'b0; pcnt <= 0;
    end else begin
      if (mul_stox) fx <= mul_sbus;
      if (mul_stos) begin
        fs <= mul_sbus; running <= 1'b1; pcnt <= 0;
      end else if (running && (mul_mod_mul || mul_plain_mul)) begin
        pcnt <= pcnt + 1;
        if (pcnt == N - 1) begin
          running <= 1'b0;
          prod <= mul_mod_mul ? polyred(clmul(fx, fs)) : clmul(fx, fs);
        end
      end
    end
  end

  assign mul_done = !running && !force_lo;
  assign mul_dbus = mul_dbus_sel ? prod[2*W-1:W] : prod[W-1:0];

  // Reference model: in-flight command tracked by cycles elapsed since acceptance.
  logic           m_busy, m_mod, m_err;
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_exp;
  int             m_k;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_k <= 0; m_err <= 1'b0;
      m_a <= '0; m_b <= '0; m_mod <= 1'b0; m_exp <= '0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1; m_k <= 1; m_err <= 1'b0;
        m_a <= cmd_a; m_b <= cmd_b; m_mod <= cmd_mod;
        m_exp <= cmd_mod ? polyred(clmul(cmd_a, cmd_b)) : clmul(cmd_a, cmd_b);
      end
    end else begin
      if (m_k >= N + 6 && rsp_ready) m_busy <= 1'b0;
      else m_k <= m_k + 1;
`ifdef GF2M_MUL_SEQ_CHECK_EN
      if ((m_k == 1 || m_k == 2 || m_k == N + 3) && !mul_done) m_err <= 1'b1;
`endif
    end
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int mod_seen = 0, plain_seen = 0, sel_seen = 0;

  task automatic monitor();
    logic [8:0]   ectl, actl;
    logic [W-1:0] esbus;
    forever begin
      @(negedge clk);
      ectl  = '0;
      esbus = '0;
      if (!m_busy) begin
        ectl[8] = 1'b1;
      end else begin
        ectl[7] = 1'b1;
        if (m_k == 1) begin ectl[6] = 1'b1; esbus = m_a; end
        if (m_k == 2) begin ectl[5] = 1'b1; ectl[4] = 1'b1; esbus = m_b; end
        if (m_k >= 3 && m_k <= N + 2) begin ectl[3] = m_mod; ectl[2] = !m_mod; end
        if (m_k == N + 5) ectl[1] = 1'b1;
        if (m_k >= N + 6) ectl[0] = 1'b1;
      end
      actl = {cmd_ready, busy, mul_stox, mul_stos, mul_clear,
              mul_mod_mul, mul_plain_mul, mul_dbus_sel, rsp_valid};
      chk("ctrl", {{(2*W-9){1'b0}}, actl}, {{(2*W-9){1'b0}}, ectl});
      chk("sbus", {{W{1'b0}}, mul_sbus}, {{W{1'b0}}, esbus});
      if (m_busy && m_k >= N + 6) begin
        chk("rsp_data", {rsp_hi, rsp_lo}, m_exp);
        chk("rsp_err", {{(2*W-1){1'b0}}, rsp_err}, {{(2*W-1){1'b0}}, m_err});
      end
      if (mul_mod_mul) mod_seen++;
      if (mul_plain_mul) plain_seen++;
      if (mul_dbus_sel) sel_seen++;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    bit got = 0;
    cmd_a = a; cmd_b = b; cmd_mod = m; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("accept_timeout", {511'd0, got}, {511'd0, 1'b1});
  endtask

  task automatic wait_rsp(output int cyc);
    bit got = 0;
    cyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) got = 1;
    end
    chk("rsp_timeout", {511'd0, got}, {511'd0, 1'b1});
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
  endtask

  task automatic stimulus();
    int cyc, m0, p0, s0;
    logic [W-1:0] big;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_mod = 1'b0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b1; force_lo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", {506'd0, mul_mod_mul, mul_plain_mul, mul_stos, mul_stox, mul_clear, mul_dbus_sel}, '0);
    chk("reset_rsp", {rsp_hi, rsp_lo}, '0);
    chk("reset_flags", {509'd0, rsp_valid, rsp_err, busy}, '0);
    @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {511'd0, cmd_ready}, {511'd0, 1'b1});
    @(posedge clk); #1;

    // Plain 3*3 = x^2+1 with latency check.
    send(256'h3, 256'h3, 1'b0);
    wait_rsp(cyc);
    chk("lat", cyc, 38);
    chk("p33_lo", {256'd0, rsp_lo}, 512'h5);
    chk("p33_hi", {256'd0, rsp_hi}, 512'h0);
    chk("p33_err", {511'd0, rsp_err}, '0);
    finish_rsp();

    // Top bit times x crosses into the high half.
    big = '0; big[W-1] = 1'b1;
    s0 = sel_seen;
    send(big, 256'h2, 1'b0);
    wait_rsp(cyc);
    chk("pbig_lo", {256'd0, rsp_lo}, 512'h0);
    chk("pbig_hi", {256'd0, rsp_hi}, 512'h1);
    chk("sel_cycles", sel_seen - s0, 1);
    finish_rsp();

    // Modular multiply by one.
    m0 = mod_seen; p0 = plain_seen;
    send(256'h1, 256'h1234, 1'b1);
    wait_rsp(cyc);
    chk("mod_lo", {256'd0, rsp_lo}, 512'h1234);
    chk("mod_hi", {256'd0, rsp_hi}, 512'h0);
    chk("mod_cycles", mod_seen - m0, N);
    chk("plain_cycles", plain_seen - p0, 0);
    finish_rsp();

    // Modular with a reduction actually taking place; model-only check.
    big = '0; big[200] = 1'b1; big[5] = 1'b1;
    send(big, 256'hdead_beef_0123_4567, 1'b1);
    wait_rsp(cyc);
    finish_rsp();
    send({8{32'hA5C3_0F96}}, {8{32'h1357_9BDF}}, 1'b0);
    wait_rsp(cyc);
    finish_rsp();

    // Backpressure with an ignored command pulse.
    rsp_ready = 1'b0;
    send(256'h7, 256'h5, 1'b0);
    wait_rsp(cyc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmd_valid = (i == 3); cmd_a = 256'hff; cmd_b = 256'hff; cmd_mod = 1'b1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_lo", {256'd0, rsp_lo}, 512'h1b);
    chk("bp_hold", {509'd0, rsp_valid, cmd_ready, busy}, {509'd0, 3'b101});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", {510'd0, busy, cmd_ready}, {510'd0, 2'b01});
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_queue", {511'd0, busy}, '0);

    // Reset in MUL cycle 10.
    send(256'h3, 256'h3, 1'b0);
    repeat (12) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_strobes", {506'd0, mul_mod_mul, mul_plain_mul, mul_stos, mul_stox, mul_clear, mul_dbus_sel}, '0);
    chk("rst_sbus", {256'd0, mul_sbus}, '0);
    chk("rst_flags", {509'd0, rsp_valid, busy, cmd_ready}, {509'd0, 3'b001});
    @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {511'd0, cmd_ready}, {511'd0, 1'b1});
    @(posedge clk); #1;
    send(256'h3, 256'h3, 1'b0);
    wait_rsp(cyc);
    chk("rst_p33", {rsp_hi, rsp_lo}, 512'h5);
    finish_rsp();

    // Completion failure: done held low for the whole command.
    force_lo = 1'b1;
    send(256'h3, 256'h6, 1'b0);
    wait_rsp(cyc);
    force_lo = 1'b0;
    chk("err_lo", {256'd0, rsp_lo}, 512'ha);
`ifdef GF2M_MUL_SEQ_CHECK_EN
    chk("err_set", {511'd0, rsp_err}, {511'd0, 1'b1});
`else
    chk("err_tied", {511'd0, rsp_err}, '0);
`endif
    finish_rsp();
    send(256'h2, 256'h2, 1'b0);
    wait_rsp(cyc);
    chk("err_clr", {511'd0, rsp_err}, '0);
    chk("err_clr_lo", {256'd0, rsp_lo}, 512'h4);
    finish_rsp();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf2m_mul_seq.md
Name: gf2m_mul_seq

Overview:
Command-level sequencer for the GF(2^m) shift-and-add multiplier. Accepts one multiply command at a time on a valid/ready interface and drives the multiplier's strobes: operand loads, accumulator clear, fixed-length multiply burst, wait for completion, and two-half result readout. Returns the full 2*WIDTH product on a valid/ready response interface. Sits between the ECC point-arithmetic microsequencer and one multiplier instance. The irreducible polynomial inputs are driven elsewhere.

Parameters:
WIDTH, 256, operand width; equals the multiplier's word width.
MUL_STEP, 8, bits per multiplier cycle; must match the multiplier instance and divide WIDTH. Elaboration error otherwise.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer accepts command
cmd_mod  in  1  1 = modular multiply, 0 = plain multiply
cmd_a  in  WIDTH  operand loaded into multiplier x register
cmd_b  in  WIDTH  operand loaded into multiplier scanned s register
rsp_valid  out  1  result present
rsp_ready  in  1  consumer takes result
rsp_lo  out  WIDTH  product bits [WIDTH-1:0]
rsp_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
rsp_err  out  1  completion-check failure (see Optional Feature)
busy  out  1  high in every state except IDLE
mul_mod_mul, mul_plain_mul, mul_stos, mul_stox, mul_clear, mul_dbus_sel  out  1 each  multiplier strobes
mul_sbus  out  WIDTH  multiplier source bus
mul_dbus  in  WIDTH  multiplier result bus (combinational select of half)
mul_done  in  1  multiplier done

Behaviour:
- Reset (async, reset_n=0): state IDLE. All mul_* outputs 0. rsp_valid=0, rsp_lo=rsp_hi=0, rsp_err=0, busy=0, step counter 0, captured mode 0. After release, cmd_ready=1.
- cmd_ready = (state==IDLE), combinational from state. A command is accepted on the edge where cmd_valid & cmd_ready. cmd_a, cmd_b and cmd_mod are captured into internal registers at that edge.
- N = WIDTH/MUL_STEP (32 by default).
- IDLE -> LOAD_X on accept.
- LOAD_X (1 cycle): mul_stox=1, mul_sbus=captured a. -> LOAD_S.
- LOAD_S (1 cycle): mul_stos=1, mul_clear=1, mul_sbus=captured b. -> MUL.
- MUL (exactly N cycles): mul_mod_mul=mode, mul_plain_mul=~mode. A counter runs from 0 to N-1. -> WAIT on the Nth cycle.
- WAIT (1 cycle): all op strobes 0. mul_done is expected high this cycle. -> RD_LO.
- RD_LO (1 cycle): mul_dbus_sel=0; rsp_lo <= mul_dbus. -> RD_HI.
- RD_HI (1 cycle): mul_dbus_sel=1; rsp_hi <= mul_dbus. -> RESP.
- RESP: rsp_valid=1. rsp_lo, rsp_hi and rsp_err stay stable until rsp_valid & rsp_ready. On that edge -> IDLE. The next command can be accepted one cycle later.
- Latency: accept at edge 0 -> rsp_valid first high in cycle N+6 (38 by default). Throughput: one command per N+7 cycles with rsp_ready held high.
- mul_sbus = 0 outside LOAD_X and LOAD_S. mul_dbus_sel = 0 outside RD_HI. Mod and plain strobes are never high together and are never high outside MUL.
- For a modular command, rsp_hi holds whatever the multiplier outputs (0 for a polynomial of degree <= WIDTH). It is not forced.
- cmd_valid in a non-IDLE state is ignored and is not queued.
- reset_n low mid-operation returns to IDLE immediately. The result is discarded and the multiplier strobes drop asynchronously. The multiplier is reset by the same reset net.

Optional Feature:
GF2M_MUL_SEQ_CHECK_EN
- Defined: in WAIT, if mul_done=0, a sticky error flag is set. The flag is cleared when the next command is accepted. rsp_err reflects the flag in RESP. A cycle in LOAD_X or LOAD_S with mul_done=0 also sets the flag.
- Undefined: no check logic; rsp_err tied 0.

Test Plan:
- Plain multiply, a=0x3, b=0x3 -> rsp_lo=0x5, rsp_hi=0, rsp_err=0, rsp_valid at cycle 38 after accept.
- Plain multiply, a=1<<255, b=0x2 -> rsp_lo=0, rsp_hi=0x1. Check mul_dbus_sel=1 only in RD_HI.
- Modular multiply, poly x^163+x^7+x^6+x^3+1 on the multiplier, a=0x1, b=0x1234 -> rsp_lo=0x1234, rsp_hi=0. mul_mod_mul high for exactly 32 cycles, mul_plain_mul never high.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> outputs stable, cmd_ready=0, busy=1, and a cmd_valid pulse is ignored. The next accept occurs only after the rsp handshake.
- Reset: reset_n pulsed low at MUL cycle 10 -> all mul_* outputs 0 immediately, rsp_valid=0, cmd_ready=1 after release. A following a=0x3, b=0x3 command returns 0x5.
- With GF2M_MUL_SEQ_CHECK_EN: mul_done forced 0 during WAIT -> rsp_err=1. Next good command -> rsp_err=0.
